vga_pattern_gen: RTL and testbench



---
 rtl/vga_pkg.sv | 67 ++++++
 rtl/vga_box_animator.sv | 73 +++++++
 rtl/vga_pattern_gen.sv | 96 +++++++++
 tb/tb_vga_pattern_gen.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared types, defaults and colour helpers for the VGA pattern generator.
package vga_pkg;

  localparam int unsigned COORD_W      = 12;
  localparam int unsigned H_ACTIVE_DEF = 640;
  localparam int unsigned V_ACTIVE_DEF = 480;
  localparam int unsigned BOX_SIZE_DEF = 32;
  localparam int unsigned BAR_W_DEF    = 80;

  typedef enum logic [1:0] {
    MODE_BARS  = 2'd0,
    MODE_CHECK = 2'd1,
    MODE_BOX   = 2'd2,
    MODE_RSVD  = 2'd3
  } mode_e;

  // bit1 set = moving up, bit0 set = moving left
  typedef enum logic [1:0] {
    MOVE_DR = 2'b00,
    MOVE_DL = 2'b01,
    MOVE_UR = 2'b10,
    MOVE_UL = 2'b11
  } box_dir_e;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  localparam rgb_t C_WHITE   = 24'hFF_FF_FF;
  localparam rgb_t C_YELLOW  = 24'hFF_FF_00;
  localparam rgb_t C_CYAN    = 24'h00_FF_FF;
  localparam rgb_t C_GREEN   = 24'h00_FF_00;
  localparam rgb_t C_MAGENTA = 24'hFF_00_FF;
  localparam rgb_t C_RED     = 24'hFF_00_00;
  localparam rgb_t C_BLUE    = 24'h00_00_FF;
  localparam rgb_t C_BLACK   = 24'h00_00_00;
  localparam rgb_t C_BG      = 24'h20_20_20;

  // Number of bar boundaries at or left of x; saturates at 7 without a divider.
  function automatic logic [2:0] bar_index(input logic [COORD_W-1:0] x,
                                           input int unsigned bar_w);
    logic [2:0] idx;
    idx = 3'd0;
    for (int unsigned i = 1; i < 8; i++) begin
      if (32'(x) >= i * bar_w) idx = 3'(i);
    end
    return idx;
  endfunction

  function automatic rgb_t bar_colour(input logic [2:0] idx);
    rgb_t c;
    case (idx)
      3'd0:    c = C_WHITE;
      3'd1:    c = C_YELLOW;
      3'd2:    c = C_CYAN;
      3'd3:    c = C_GREEN;
      3'd4:    c = C_MAGENTA;
      3'd5:    c = C_RED;
      3'd6:    c = C_BLUE;
      default: c = C_BLACK;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/vga_box_animator.sv
// Bouncing-box position/direction FSM, stepping one pixel per axis on each frame tick.
module vga_box_animator
  import vga_pkg::*;
#(
  parameter int unsigned H_ACTIVE = H_ACTIVE_DEF,
  parameter int unsigned V_ACTIVE = V_ACTIVE_DEF,
  parameter int unsigned BOX_SIZE = BOX_SIZE_DEF
) (
  input  logic               clk_in,
  input  logic               rst,
  input  logic               frame_tick,
  output logic [COORD_W-1:0] box_x,
  output logic [COORD_W-1:0] box_y
);

  localparam logic [COORD_W-1:0] X_LIM = COORD_W'(H_ACTIVE - BOX_SIZE);
  localparam logic [COORD_W-1:0] Y_LIM = COORD_W'(V_ACTIVE - BOX_SIZE);

  box_dir_e           r_dir;
  box_dir_e           w_dir_next;
  logic [COORD_W-1:0] r_box_x;
  logic [COORD_W-1:0] r_box_y;
  logic [COORD_W-1:0] w_x_next;
  logic [COORD_W-1:0] w_y_next;
  logic               w_left;
  logic               w_up;
  logic               w_left_next;
  logic               w_up_next;

  always_ff @(posedge clk_in) begin
    if (rst) begin
      r_dir   <= MOVE_DR;
      r_box_x <= '0;
      r_box_y <= '0;
    end else begin
      r_dir   <= w_dir_next;
      r_box_x <= w_x_next;
      r_box_y <= w_y_next;
    end
  end

  // Step, then reverse an axis on the same tick it lands on its edge.
  always_comb begin
    w_x_next    = r_box_x;
    w_y_next    = r_box_y;
    w_dir_next  = r_dir;
    w_left      = r_dir[0];
    w_up        = r_dir[1];
    w_left_next = w_left;
    w_up_next   = w_up;
    if (frame_tick) begin
      if (w_left) begin
        w_x_next    = r_box_x - COORD_W'(1);
        w_left_next = (w_x_next != '0);
      end else begin
        w_x_next    = r_box_x + COORD_W'(1);
        w_left_next = (w_x_next == X_LIM);
      end
      if (w_up) begin
        w_y_next  = r_box_y - COORD_W'(1);
        w_up_next = (w_y_next != '0);
      end else begin
        w_y_next  = r_box_y + COORD_W'(1);
        w_up_next = (w_y_next == Y_LIM);
      end
      w_dir_next = box_dir_e'({w_up_next, w_left_next});
    end
  end

  assign box_x = r_box_x;
  assign box_y = r_box_y;

endmodule

// File: rtl/vga_pattern_gen.sv
// Two-stage pixel-enable pipeline producing bars / checker / bouncing-box colours.
// Optional white screen border when PATTERN_BORDER_EN is defined.
module vga_pattern_gen
  import vga_pkg::*;
#(
  parameter int unsigned H_ACTIVE = H_ACTIVE_DEF,
  parameter int unsigned V_ACTIVE = V_ACTIVE_DEF,
  parameter int unsigned BOX_SIZE = BOX_SIZE_DEF,
  parameter int unsigned BAR_W    = BAR_W_DEF
) (
  input  logic        clk_in,
  input  logic        rst,
  input  logic        clock_div,
  input  logic [11:0] xpose,
  input  logic [11:0] ypose,
  input  logic        disp_active,
  input  logic [1:0]  mode,
  output logic [7:0]  R,
  output logic [7:0]  G,
  output logic [7:0]  A,
  output logic        frame_tick
);

  logic               w_tick;
  logic               r_frame_tick;
  mode_e              r_mode;
  logic [COORD_W-1:0] r_s1_x;
  logic [COORD_W-1:0] r_s1_y;
  logic               r_s1_de;
  rgb_t               r_rgb;
  rgb_t               w_pix;
  logic [COORD_W-1:0] w_box_x;
  logic [COORD_W-1:0] w_box_y;
  logic               w_in_box;

  assign w_tick = clock_div && (xpose == '0) && (ypose == COORD_W'(V_ACTIVE));

  vga_box_animator #(
    .H_ACTIVE (H_ACTIVE),
    .V_ACTIVE (V_ACTIVE),
    .BOX_SIZE (BOX_SIZE)
  ) u_box (
    .clk_in     (clk_in),
    .rst        (rst),
    .frame_tick (r_frame_tick),
    .box_x      (w_box_x),
    .box_y      (w_box_y)
  );

  // Mode is sampled at the frame boundary; pipeline stages move only on pixel enables.
  always_ff @(posedge clk_in) begin
    if (rst) begin
      r_frame_tick <= 1'b0;
      r_mode       <= MODE_BARS;
      r_s1_x       <= '0;
      r_s1_y       <= '0;
      r_s1_de      <= 1'b0;
      r_rgb        <= C_BLACK;
    end else begin
      r_frame_tick <= w_tick;
      if (w_tick) r_mode <= mode_e'(mode);
      if (clock_div) begin
        r_s1_x  <= xpose;
        r_s1_y  <= ypose;
        r_s1_de <= disp_active;
        r_rgb   <= w_pix;
      end
    end
  end

  assign w_in_box = (r_s1_x >= w_box_x) && (r_s1_x < w_box_x + COORD_W'(BOX_SIZE)) &&
                    (r_s1_y >= w_box_y) && (r_s1_y < w_box_y + COORD_W'(BOX_SIZE));

  always_comb begin
    w_pix = C_BLACK;
    if (r_s1_de) begin
      case (r_mode)
        MODE_CHECK: w_pix = (r_s1_x[4] ^ r_s1_y[4]) ? C_WHITE : C_BLACK;
        MODE_BOX:   w_pix = w_in_box ? C_RED : C_BG;
        default:    w_pix = bar_colour(bar_index(r_s1_x, BAR_W));
      endcase
`ifdef PATTERN_BORDER_EN
      if ((r_s1_x == '0) || (r_s1_x == COORD_W'(H_ACTIVE - 1)) ||
          (r_s1_y == '0) || (r_s1_y == COORD_W'(V_ACTIVE - 1))) begin
        w_pix = C_WHITE;
      end
`endif
    end
  end

  assign R          = r_rgb.r;
  assign G          = r_rgb.g;
  assign A          = r_rgb.b;
  assign frame_tick = r_frame_tick;

endmodule

// File: tb/tb_vga_pattern_gen.sv
// Directed bench for vga_pattern_gen with an expected-colour queue.
module tb_vga_pattern_gen;

  logic        clk_in = 1'b0;
  logic        rst;
  logic        clock_div;
  logic [11:0] xpose;
  logic [11:0] ypose;
  logic        disp_active;
  logic [1:0]  mode;
  logic [7:0]  R;
  logic [7:0]  G;
  logic [7:0]  A;
  logic        frame_tick;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [23:0] exp_q[$];

  // Independent box model: position and step per axis.
  int bx = 0, by = 0, dx = 1, dy = 1, n_ticks = 0;

  int          bar_x [9] = '{0, 85, 180, 250, 330, 479, 500, 639, 700};
  logic [23:0] bar_c [9] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00, 24'hFF00FF,
                             24'hFF0000, 24'h0000FF, 24'h000000, 24'h000000};

  always #5 clk_in = ~clk_in;

  vga_pattern_gen dut (
    .clk_in      (clk_in),
    .rst         (rst),
    .clock_div   (clock_div),
    .xpose       (xpose),
    .ypose       (ypose),
    .disp_active (disp_active),
    .mode        (mode),
    .R           (R),
    .G           (G),
    .A           (A),
    .frame_tick  (frame_tick)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Pop the oldest expectation and compare with the current outputs.
  task automatic pop_chk(input string tag);
    logic [23:0] e;
    if (exp_q.size() == 0) begin
      chk({tag, "_empty_q"}, 32'(1), 32'(0));
    end else begin
      e = exp_q.pop_front();
      chk(tag, 32'({R, G, A}), 32'(e));
    end
  endtask

  // Drive one pixel, follow it with a blanked pixel, and check after the second enable.
  task automatic send(input string tag, input int x, input int y, input logic de,
                      input logic [23:0] e);
    logic [23:0] ee;
    ee = e;
`ifdef PATTERN_BORDER_EN
    if (de && (x == 0 || x == 639 || y == 0 || y == 479)) ee = 24'hFFFFFF;
`endif
    exp_q.push_back(ee);
    clock_div   = 1'b1;
    xpose       = 12'(x);
    ypose       = 12'(y);
    disp_active = de;
    @(negedge clk_in);
    xpose       = 12'd5;
    ypose       = 12'd5;
    disp_active = 1'b0;
    @(negedge clk_in);
    pop_chk(tag);
  endtask

  task automatic tick();
    clock_div   = 1'b1;
    xpose       = 12'd0;
    ypose       = 12'd480;
    disp_active = 1'b0;
    @(negedge clk_in);
    chk("tick_hi", 32'(frame_tick), 32'(1));
    ypose = 12'd481;
    @(negedge clk_in);
    chk("tick_lo", 32'(frame_tick), 32'(0));
    n_ticks++;
    bx += dx;
    by += dy;
    if (bx == 608 || bx == 0) dx = -dx;
    if (by == 448 || by == 0) dy = -dy;
  endtask

  task automatic chk_box(input string tag);
    chk({tag, "_x"}, 32'(dut.u_box.box_x), 32'(bx));
    chk({tag, "_y"}, 32'(dut.u_box.box_y), 32'(by));
  endtask

  initial begin
    rst = 1'b1; clock_div = 1'b1; xpose = '0; ypose = '0; disp_active = 1'b0; mode = 2'd0;
    repeat (3) @(posedge clk_in);
    @(negedge clk_in);
    chk("rst_rgb", 32'({R, G, A}), 32'(0));
    chk("rst_tick", 32'(frame_tick), 32'(0));
    chk_box("rst_box");
    rst = 1'b0;

    // Colour bars including the clamped index beyond the last bar
    for (int i = 0; i < 9; i++) send($sformatf("bar_x%0d", bar_x[i]), bar_x[i], 10, 1'b1, bar_c[i]);
    send("bar_85", 85, 10, 1'b1, 24'hFFFF00);

    // Pixel enable low: outputs hold, and a would-be tick is ignored
    clock_div = 1'b0; xpose = 12'd0; ypose = 12'd480; disp_active = 1'b1;
    repeat (5) @(negedge clk_in);
    chk("hold_rgb", 32'({R, G, A}), 32'(24'hFFFF00));
    chk("hold_tick", 32'(frame_tick), 32'(0));
    chk_box("hold_box");
    ypose = 12'd100;
    clock_div = 1'b1;
    @(negedge clk_in);
    chk("resume_rgb", 32'({R, G, A}), 32'(0));

    // Mode change mid-frame stays bars until the frame tick
    mode = 2'd1;
    send("pre_tick_bars", 16, 16, 1'b1, 24'hFFFFFF);
    tick();
    chk_box("box_t1");
    send("chk_16_16", 16, 16, 1'b1, 24'h000000);
    send("chk_16_0", 16, 0, 1'b1, 24'hFFFFFF);
    send("chk_blank", 16, 0, 1'b0, 24'h000000);
    send("chk_0_200", 0, 200, 1'b1, 24'h000000);

    // Bouncing box over 608 frame ticks
    mode = 2'd2;
    while (n_ticks < 608) begin
      tick();
      if (n_ticks == 448) chk("box_y_448", 32'(dut.u_box.box_y), 32'(448));
    end
    chk_box("box_t608");
    chk("box_x_608", 32'(dut.u_box.box_x), 32'(608));
    chk("box_y_fell", 32'(dut.u_box.box_y), 32'(288));
    send("box_tl", bx, by, 1'b1, 24'hFF0000);
    send("box_left", bx - 1, by, 1'b1, 24'h202020);
    send("box_br", bx + 31, by + 31, 1'b1, 24'hFF0000);
    send("box_below", bx, by + 32, 1'b1, 24'h202020);
    send("box_bg_0_479", 0, 479, 1'b1, 24'h202020);
    tick();
    chk("box_x_607", 32'(dut.u_box.box_x), 32'(607));
    chk_box("box_t609");

    // Reset with pixel enable low clears everything
    send("box_pre_rst", bx, by, 1'b1, 24'hFF0000);
    clock_div = 1'b0; rst = 1'b1;
    @(negedge clk_in);
    chk("midrst_rgb", 32'({R, G, A}), 32'(0));
    chk("midrst_box_x", 32'(dut.u_box.box_x), 32'(0));
    chk("midrst_box_y", 32'(dut.u_box.box_y), 32'(0));
    rst = 1'b0;
    bx = 0; by = 0; dx = 1; dy = 1;
    send("postrst_bars", 85, 10, 1'b1, 24'hFFFF00);

    // Reserved mode behaves as bars
    mode = 2'd3;
    tick();
    send("rsvd_bars", 85, 10, 1'b1, 24'hFFFF00);
    send("rsvd_bars_16", 16, 16, 1'b1, 24'hFFFFFF);
    chk_box("box_after_rsvd");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
